// File: rtl/uart_tx_engine.sv
// rtl/uart_tx_engine.sv - UART transmit engine: FIFO fetch and start/data/parity/stop serialiser
module uart_tx_engine #(
  parameter int DATA_WIDTH     = 10,
  parameter int BAUD_DIV_WIDTH = 16
) (
  input  logic                      clk,
  input  logic                      rstn,
  input  logic                      r_tx_en,
  input  logic [BAUD_DIV_WIDTH-1:0] r_baud_div,
  input  logic [2:0]                r_data_bits,
  input  logic                      r_parity_en,
  input  logic                      r_parity_odd,
  input  logic                      r_stop2,
  input  logic                      tx_fifo_empty,
  input  logic [DATA_WIDTH-1:0]     tx_fifo_rdata,
  output logic                      tx_fifo_re,
  output logic                      txd,
  output logic                      tx_busy,
  output logic                      tx_done
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_LOAD,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  state_t                    state;
  state_t                    state_nxt;

  // Frame-local copies of the configuration, frozen at LOAD
  logic [BAUD_DIV_WIDTH-1:0] div_l;
  logic [3:0]                nbits_l;
  logic                      par_en_l;
  logic                      par_odd_l;
  logic                      stop2_l;

  logic [8:0]                shift_reg;
  logic [BAUD_DIV_WIDTH-1:0] baud_cnt;
  logic [3:0]                bit_idx;
  logic                      stop_idx;
  logic                      par_acc;

  logic                      bit_end;
  logic [3:0]                nbits_sel;
  logic                      unused_rdata;

  // Word bits above the 9-bit payload carry nothing for the transmitter
  assign unused_rdata = ^tx_fifo_rdata[DATA_WIDTH-1:9];

  // A bit period ends on the cycle the down-counter sits at zero
  assign bit_end = (baud_cnt == '0);
  assign tx_busy = (state != S_IDLE);

  // Data length code: 0..4 select 5..9 bits, the reserved codes fall back to 9
  always_comb begin
    nbits_sel = 4'd9;
    if (r_data_bits <= 3'd4) begin
      nbits_sel = {1'b0, r_data_bits} + 4'd5;
    end
  end

  // State register
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic with the FIFO read strobe and end-of-frame pulse
  always_comb begin
    state_nxt  = state;
    tx_fifo_re = 1'b0;
    tx_done    = 1'b0;
    case (state)
      S_IDLE: begin
        if (r_tx_en && !tx_fifo_empty) begin
          tx_fifo_re = 1'b1;
          state_nxt  = S_FETCH;
        end
      end
      S_FETCH: state_nxt = S_LOAD;
      S_LOAD:  state_nxt = S_START;
      S_START: begin
        if (bit_end) begin
          state_nxt = S_DATA;
        end
      end
      S_DATA: begin
        if (bit_end && (bit_idx == nbits_l - 4'd1)) begin
          state_nxt = par_en_l ? S_PARITY : S_STOP;
        end
      end
      S_PARITY: begin
        if (bit_end) begin
          state_nxt = S_STOP;
        end
      end
      S_STOP: begin
        if (bit_end && (stop_idx == stop2_l)) begin
          tx_done   = 1'b1;
          state_nxt = S_IDLE;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Line driver: start low, data LSB first, parity from the running XOR, idle/stop high
  always_comb begin
    txd = 1'b1;
    case (state)
      S_START:  txd = 1'b0;
      S_DATA:   txd = shift_reg[0];
      S_PARITY: txd = par_acc ^ par_odd_l;
      default:  txd = 1'b1;
    endcase
  end

  // Frame datapath: capture word and config at LOAD, then pace bits with the baud counter
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      shift_reg <= '0;
      div_l     <= '0;
      baud_cnt  <= '0;
      nbits_l   <= '0;
      par_en_l  <= 1'b0;
      par_odd_l <= 1'b0;
      stop2_l   <= 1'b0;
      bit_idx   <= '0;
      stop_idx  <= 1'b0;
      par_acc   <= 1'b0;
    end else begin
      case (state)
        S_LOAD: begin
          shift_reg <= tx_fifo_rdata[8:0];
          div_l     <= r_baud_div;
          baud_cnt  <= r_baud_div;
          nbits_l   <= nbits_sel;
          par_en_l  <= r_parity_en;
          par_odd_l <= r_parity_odd;
          stop2_l   <= r_stop2;
          bit_idx   <= '0;
          stop_idx  <= 1'b0;
          par_acc   <= 1'b0;
        end
        S_START, S_DATA, S_PARITY, S_STOP: begin
          if (bit_end) begin
            baud_cnt <= div_l;
            if (state == S_DATA) begin
              shift_reg <= {1'b0, shift_reg[8:1]};
              par_acc   <= par_acc ^ shift_reg[0];
              bit_idx   <= bit_idx + 4'd1;
            end
            if (state == S_STOP) begin
              stop_idx <= 1'b1;
            end
          end else begin
            baud_cnt <= baud_cnt - 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_engine.sv
// tb/tb_uart_tx_engine.sv - self-checking bench for uart_tx_engine
module tb_uart_tx_engine;

  logic        clk = 1'b0;
  logic        rstn;
  logic        r_tx_en;
  logic [15:0] r_baud_div;
  logic [2:0]  r_data_bits;
  logic        r_parity_en;
  logic        r_parity_odd;
  logic        r_stop2;
  logic        tx_fifo_empty;
  logic [9:0]  tx_fifo_rdata = '0;
  logic        tx_fifo_re;
  logic        txd;
  logic        tx_busy;
  logic        tx_done;

  always #5 clk = ~clk;

  uart_tx_engine #(.DATA_WIDTH(10), .BAUD_DIV_WIDTH(16)) dut (
    .clk           (clk),
    .rstn          (rstn),
    .r_tx_en       (r_tx_en),
    .r_baud_div    (r_baud_div),
    .r_data_bits   (r_data_bits),
    .r_parity_en   (r_parity_en),
    .r_parity_odd  (r_parity_odd),
    .r_stop2       (r_stop2),
    .tx_fifo_empty (tx_fifo_empty),
    .tx_fifo_rdata (tx_fifo_rdata),
    .tx_fifo_re    (tx_fifo_re),
    .txd           (txd),
    .tx_busy       (tx_busy),
    .tx_done       (tx_done)
  );

  typedef struct {
    logic [12:0] bits;
    int          nb;
    int          div;
  } frame_t;

  typedef struct {
    int         div;
    logic [2:0] dbits;
    logic       pen;
    logic       podd;
    logic       stop2;
    logic [9:0] word;
    int         ndata;
    logic       par_bit;
    int         clks;
  } vec_t;

  logic [9:0] fifo_q[$];
  frame_t     sb_q[$];
  int         gap_q[$];
  vec_t       vecs[6];

  int   checks = 0;
  int   failures = 0;
  int   frames_seen = 0;
  int   last_clks = 0;
  int   high_run = 0;
  int   re_cnt = 0;
  int   done_cnt = 0;
  logic mon_en = 1'b1;

  assign tx_fifo_empty = (fifo_q.size() == 0);

  // FIFO model with registered read data
  always @(posedge clk) begin
    if (tx_fifo_re && fifo_q.size() != 0) begin
      tx_fifo_rdata <= fifo_q.pop_front();
    end
  end

  // Strobe counters
  always @(negedge clk) begin
    if (tx_fifo_re) re_cnt <= re_cnt + 1;
    if (tx_done) done_cnt <= done_cnt + 1;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  function automatic frame_t build(input logic [9:0] word, input int ndata, input logic pen,
                                   input logic par_bit, input logic stop2, input int div);
    frame_t f;
    int     k;
    f.bits    = '1;
    f.bits[0] = 1'b0;
    k = 1;
    for (int i = 0; i < ndata; i++) begin
      f.bits[k] = word[i];
      k++;
    end
    if (pen) begin
      f.bits[k] = par_bit;
      k++;
    end
    k = k + 1 + (stop2 ? 1 : 0);
    f.nb  = k;
    f.div = div;
    return f;
  endfunction

  task automatic check_frame();
    frame_t e;
    int     clks;
    logic   bad;
    logic   wrong;
    if (sb_q.size() == 0) begin
      checks++;
      failures++;
      $display("FAIL unexpected_frame actual=start_bit required=idle");
      for (int i = 0; i < 2000 && tx_busy; i++) @(negedge clk);
      return;
    end
    e = sb_q.pop_front();
    gap_q.push_back(high_run);
    clks = 0;
    for (int b = 0; b < e.nb; b++) begin
      bad   = 1'b0;
      wrong = 1'b0;
      for (int c = 0; c <= e.div; c++) begin
        if (b != 0 || c != 0) @(negedge clk);
        clks++;
        if (txd !== e.bits[b]) begin
          bad   = 1'b1;
          wrong = txd;
        end
        if (b == e.nb - 1 && c == e.div) begin
          check($sformatf("frame%0d_done", frames_seen), {31'd0, tx_done}, 32'd1);
        end
      end
      checks++;
      if (bad) begin
        failures++;
        $display("FAIL frame%0d_bit%0d actual=%0b required=%0b", frames_seen, b, wrong, e.bits[b]);
      end
    end
    last_clks = clks;
    frames_seen++;
  endtask

  // Line monitor: counts idle-high cycles and decodes each frame against the scoreboard
  initial begin
    forever begin
      @(negedge clk);
      if (mon_en && rstn === 1'b1) begin
        if (txd === 1'b1) begin
          high_run++;
        end else begin
          check_frame();
          high_run = 0;
        end
      end else begin
        high_run = 0;
      end
    end
  end

  task automatic wait_frames(input int target, input int budget, input string name);
    int i;
    i = 0;
    while (frames_seen < target && i < budget) begin
      @(negedge clk);
      i++;
    end
    check(name, {31'd0, frames_seen >= target}, 32'd1);
  endtask

  task automatic wait_busy(input int budget, input string name);
    int i;
    i = 0;
    while (tx_busy !== 1'b1 && i < budget) begin
      @(negedge clk);
      i++;
    end
    check(name, {31'd0, tx_busy}, 32'd1);
  endtask

  task automatic set_cfg(input int div, input logic [2:0] dbits, input logic pen,
                         input logic podd, input logic stop2);
    r_baud_div   = 16'(div);
    r_data_bits  = dbits;
    r_parity_en  = pen;
    r_parity_odd = podd;
    r_stop2      = stop2;
  endtask

  initial begin
    int re0;
    int d0;
    int n0;

    vecs[0] = '{3, 3'd3, 1'b0, 1'b0, 1'b0, 10'h055, 8, 1'b0, 40};
    vecs[1] = '{0, 3'd2, 1'b1, 1'b0, 1'b0, 10'h041, 7, 1'b0, 10};
    vecs[2] = '{1, 3'd0, 1'b1, 1'b1, 1'b1, 10'h3FF, 5, 1'b0, 18};
    vecs[3] = '{2, 3'd4, 1'b1, 1'b0, 1'b0, 10'h1A5, 9, 1'b1, 36};
    vecs[4] = '{1, 3'd7, 1'b1, 1'b1, 1'b0, 10'h2FF, 9, 1'b1, 24};
    vecs[5] = '{0, 3'd1, 1'b0, 1'b0, 1'b1, 10'h0C3, 6, 1'b0, 9};

    rstn    = 1'b0;
    r_tx_en = 1'b0;
    set_cfg(0, 3'd3, 1'b0, 1'b0, 1'b0);
    repeat (3) @(negedge clk);
    check("rst_txd", {31'd0, txd}, 32'd1);
    check("rst_busy", {31'd0, tx_busy}, 32'd0);
    check("rst_done", {31'd0, tx_done}, 32'd0);
    check("rst_re", {31'd0, tx_fifo_re}, 32'd0);
    rstn = 1'b1;
    @(negedge clk);
    r_tx_en = 1'b1;

    for (int v = 0; v < 6; v++) begin
      set_cfg(vecs[v].div, vecs[v].dbits, vecs[v].pen, vecs[v].podd, vecs[v].stop2);
      sb_q.push_back(build(vecs[v].word, vecs[v].ndata, vecs[v].pen, vecs[v].par_bit,
                           vecs[v].stop2, vecs[v].div));
      re0 = re_cnt;
      d0  = done_cnt;
      n0  = frames_seen;
      fifo_q.push_back(vecs[v].word);
      wait_frames(n0 + 1, 1000, $sformatf("vec%0d_timeout", v));
      repeat (3) @(negedge clk);
      check($sformatf("vec%0d_re", v), re_cnt - re0, 1);
      check($sformatf("vec%0d_done", v), done_cnt - d0, 1);
      check($sformatf("vec%0d_clks", v), last_clks, vecs[v].clks);
    end

    // Three preloaded words sent back to back
    r_tx_en = 1'b0;
    set_cfg(1, 3'd3, 1'b0, 1'b0, 1'b0);
    sb_q.push_back(build(10'h0A3, 8, 1'b0, 1'b0, 1'b0, 1));
    sb_q.push_back(build(10'h15C, 8, 1'b0, 1'b0, 1'b0, 1));
    sb_q.push_back(build(10'h1FF, 8, 1'b0, 1'b0, 1'b0, 1));
    fifo_q.push_back(10'h0A3);
    fifo_q.push_back(10'h15C);
    fifo_q.push_back(10'h1FF);
    gap_q.delete();
    re0 = re_cnt;
    d0  = done_cnt;
    n0  = frames_seen;
    @(negedge clk);
    r_tx_en = 1'b1;
    wait_frames(n0 + 3, 2000, "b2b_timeout");
    repeat (3) @(negedge clk);
    check("b2b_re", re_cnt - re0, 3);
    check("b2b_done", done_cnt - d0, 3);
    check("b2b_frames", gap_q.size(), 3);
    if (gap_q.size() == 3) begin
      check("b2b_gap1", gap_q[1], 3);
      check("b2b_gap2", gap_q[2], 3);
    end

    // Register changes mid-frame only affect the following frame
    set_cfg(3, 3'd3, 1'b0, 1'b0, 1'b0);
    sb_q.push_back(build(10'h0C6, 8, 1'b0, 1'b0, 1'b0, 3));
    sb_q.push_back(build(10'h05A, 7, 1'b0, 1'b0, 1'b0, 7));
    d0 = done_cnt;
    n0 = frames_seen;
    fifo_q.push_back(10'h0C6);
    fifo_q.push_back(10'h05A);
    wait_busy(20, "cfg_busy");
    repeat (10) @(negedge clk);
    r_baud_div  = 16'd7;
    r_data_bits = 3'd2;
    wait_frames(n0 + 2, 3000, "cfg_timeout");
    repeat (3) @(negedge clk);
    check("cfg_done", done_cnt - d0, 2);
    check("cfg_clks2", last_clks, 72);

    // Enable dropped mid DATA: frame finishes, second word stays queued
    set_cfg(1, 3'd3, 1'b0, 1'b0, 1'b0);
    sb_q.push_back(build(10'h0F0, 8, 1'b0, 1'b0, 1'b0, 1));
    re0 = re_cnt;
    d0  = done_cnt;
    n0  = frames_seen;
    fifo_q.push_back(10'h0F0);
    fifo_q.push_back(10'h00F);
    wait_busy(20, "en_busy");
    repeat (6) @(negedge clk);
    r_tx_en = 1'b0;
    wait_frames(n0 + 1, 1000, "en_timeout");
    repeat (40) @(negedge clk);
    check("en_re", re_cnt - re0, 1);
    check("en_done", done_cnt - d0, 1);
    check("en_fifo_left", fifo_q.size(), 1);
    check("en_idle", {31'd0, tx_busy}, 32'd0);
    fifo_q.delete();

    // Reset asserted mid DATA abandons the frame immediately
    mon_en = 1'b0;
    set_cfg(3, 3'd3, 1'b0, 1'b0, 1'b0);
    r_tx_en = 1'b1;
    fifo_q.push_back(10'h000);
    wait_busy(20, "rst_mid_busy");
    repeat (12) @(negedge clk);
    check("rst_mid_data_low", {31'd0, txd}, 32'd0);
    rstn = 1'b0;
    #1;
    check("rst_mid_txd", {31'd0, txd}, 32'd1);
    check("rst_mid_busy_low", {31'd0, tx_busy}, 32'd0);
    check("rst_mid_done", {31'd0, tx_done}, 32'd0);
    check("rst_mid_re", {31'd0, tx_fifo_re}, 32'd0);
    @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);
    mon_en = 1'b1;

    // Recovery frame after reset
    set_cfg(0, 3'd3, 1'b0, 1'b0, 1'b0);
    sb_q.push_back(build(10'h0A5, 8, 1'b0, 1'b0, 1'b0, 0));
    n0 = frames_seen;
    fifo_q.push_back(10'h0A5);
    wait_frames(n0 + 1, 500, "recov_timeout");
    repeat (3) @(negedge clk);
    check("recov_clks", last_clks, 10);
    check("sb_empty", sb_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
